// File: rtl/contador_multi.sv
// contador_multi: per-channel data-change event counters with sticky overflow and registered readout
module contador_multi #(
    parameter int NCH = 4,
    parameter int DW  = 12,
    parameter int CW  = 16,
    parameter int SAT = 0,
    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH*DW-1:0] data_in,
    input  logic [NCH-1:0]    en,
    input  logic [NCH-1:0]    clr,
    input  logic              rd_req,
    input  logic [SW-1:0]     rd_sel,
    output logic [NCH*CW-1:0] cuenta,
    output logic [NCH-1:0]    ovf,
    output logic              rd_valid,
    output logic [CW-1:0]     rd_data,
    output logic              rd_ovf,
    output logic              rd_err
);
    logic [NCH*DW-1:0] det;
    logic [CW-1:0]     cnt_a [NCH];
    logic              sel_hit;
    logic [CW-1:0]     sel_cnt;
    logic              sel_ovf;

    always_ff @(posedge clk)
        det <= reset ? '0 : data_in;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [CW-1:0] c;
        logic          o;
        logic          chg;
        logic          top;
        assign chg = det[k*DW +: DW] != data_in[k*DW +: DW];
        assign top = &c;
        always_ff @(posedge clk) begin
            if (reset || clr[k]) begin
                c <= '0;
                o <= 1'b0;
            end else if (chg && en[k]) begin
                c <= top ? ((SAT != 0) ? c : '0) : c + CW'(1);
                o <= o | top;
            end
        end
        assign cuenta[k*CW +: CW] = c;
        assign ovf[k]             = o;
        assign cnt_a[k]           = c;
    end

    always_comb begin
        sel_hit = 1'b0;
        sel_cnt = '0;
        sel_ovf = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (rd_sel == SW'(i)) begin
                sel_hit = 1'b1;
                sel_cnt = cnt_a[i];
                sel_ovf = ovf[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_ovf   <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            rd_data  <= (rd_req && sel_hit) ? sel_cnt : '0;
            rd_ovf   <= rd_req && sel_hit && sel_ovf;
            rd_err   <= rd_req && !sel_hit;
        end
    end
endmodule
